// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI slave for all four clock modes. SCK, SS and MOSI are oversampled on CLOCK.
// Frames are MSB first, with a one-entry TX holding register and back-to-back frames.
module spi_slave #(
    parameter int D_PACK      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic              C_POL,
    input  logic              C_PH,
    input  logic [D_PACK-1:0] TX_DATA,
    input  logic              TX_LOAD,
    output logic              TX_READY,
    output logic [D_PACK-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              BUSY
);

    localparam int CW = (D_PACK > 2) ? $clog2(D_PACK) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(D_PACK - 1);

    typedef enum logic { IDLE = 1'b0, ACTIVE = 1'b1 } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sck_q;
    logic                   ss_q;
    logic                   mosi_q;
    logic                   lead_p;
    logic                   trail_p;
    logic                   ss_fall_p;
    logic                   ss_rise_p;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [D_PACK-1:0]      rx_shift;
    logic [D_PACK-1:0]      tx_shift;
    logic [D_PACK-1:0]      hold_data;
    logic                   tx_ready;
    logic                   sample_p;
    logic                   shift_p;
    logic [D_PACK-1:0]      load_word;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // NOTE: every register in this file uses <= so that all stages update from
    // pre-edge values; a blocking = here would collapse the synchronizer chain.
    always_ff @(posedge CLOCK) begin
        if (!RST) begin
            sck_sync  <= {SYNC_STAGES{C_POL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= C_POL;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            lead_p    <= 1'b0;
            trail_p   <= 1'b0;
            ss_fall_p <= 1'b0;
            ss_rise_p <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync[0]  <= SCK;
            ss_sync[0]   <= SS;
            mosi_sync[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_q     <= sck_s;
            ss_q      <= ss_s;
            mosi_q    <= mosi_s;
            lead_p    <= (sck_s != sck_q) && (sck_s != C_POL);
            trail_p   <= (sck_s != sck_q) && (sck_s == C_POL);
            ss_fall_p <= ss_q && !ss_s;
            ss_rise_p <= !ss_q && ss_s;
            // A fall only counts once SS has been seen high in real pin samples.
            // This stops a select held low through reset from starting mid-transfer.
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (fill[SYNC_STAGES] & ss_q);
        end
    end

    assign sample_p  = C_PH ? trail_p : lead_p;
    assign shift_p   = C_PH ? lead_p  : trail_p;
    assign load_word = tx_ready ? '0 : hold_data;

    always_ff @(posedge CLOCK) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold_data <= '0;
            tx_ready  <= 1'b1;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall_p && armed) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                        if (!C_PH) begin
                            tx_shift <= load_word;
                            tx_ready <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise_p) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (sample_p) begin
                        rx_shift <= {rx_shift[D_PACK-2:0], mosi_q};
                        if (bit_cnt == LAST_BIT) begin
                            RX_DATA  <= {rx_shift[D_PACK-2:0], mosi_q};
                            RX_VALID <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (shift_p) begin
                        // A shift edge at count 0 starts a new frame, so it reloads instead of shifting.
                        if (bit_cnt == '0) begin
                            tx_shift <= load_word;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_shift <= {tx_shift[D_PACK-2:0], 1'b0};
                        end
                    end
                end
            endcase
            // This comes last so that a same-cycle write wins over the frame-start reload.
            if (TX_LOAD && tx_ready) begin
                hold_data <= TX_DATA;
                tx_ready  <= 1'b0;
            end
        end
    end

    assign MISO     = tx_shift[D_PACK-1];
    assign TX_READY = tx_ready;
    assign BUSY     = (state == ACTIVE);
    assign MISO_OE  = BUSY;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Bench for spi_slave. A master model drives frames in all four modes.
// Received frames are checked through an expected-RX scoreboard queue.
module tb_spi_slave;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic       CLOCK = 1'b0;
    logic       RST;
    logic       SCK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic       C_POL;
    logic       C_PH;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       BUSY;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       do_load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         rx_seen = 0;
    int         rx_pushed = 0;
    logic [7:0] rx_q[$];
    vec_t       vecs[6];

    spi_slave #(.D_PACK(8), .SYNC_STAGES(SYNC)) dut (
        .CLOCK(CLOCK), .RST(RST), .SCK(SCK), .SS(SS), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .C_POL(C_POL), .C_PH(C_PH),
        .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (RST === 1'b1 && RX_VALID === 1'b1) begin
            rx_seen++;
            if (rx_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got RX_VALID with RX_DATA 0x%0h, expected no strobe", RX_DATA);
            end else begin
                check("rx_data", 32'(RX_DATA), 32'(rx_q.pop_front()));
            end
        end
    end

    task automatic push_rx(input logic [7:0] d);
        rx_q.push_back(d);
        rx_pushed++;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_half(output int rv_at);
        rv_at = 0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge CLOCK);
            if (RX_VALID === 1'b1 && rv_at == 0) rv_at = k;
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge CLOCK);
        TX_DATA = d;
        TX_LOAD = 1'b1;
        @(negedge CLOCK);
        TX_LOAD = 1'b0;
    endtask

    task automatic run_frame(input logic cpol, input logic cpha, input logic [7:0] mosi_b,
                             input int nbits, output logic [7:0] miso_b);
        int rv;
        miso_b = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) MOSI = mosi_b[7-i];
            wait_half(rv);
            @(negedge CLOCK);
            if (!cpha) miso_b[7-i] = MISO;
            SCK = ~cpol;
            if (cpha) MOSI = mosi_b[7-i];
            wait_half(rv);
            if (!cpha && nbits == 8 && i == 7) check("rx_latency", 32'(rv), 32'(SYNC + 2));
            @(negedge CLOCK);
            if (cpha) miso_b[7-i] = MISO;
            SCK = cpol;
        end
        if (cpha) begin
            wait_half(rv);
            if (nbits == 8) check("rx_latency", 32'(rv), 32'(SYNC + 2));
        end
    endtask

    task automatic end_frame();
        int n;
        @(negedge CLOCK);
        SS = 1'b1;
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        check("busy_fall", 32'(BUSY), 32'd0);
        check("miso_oe_idle", 32'(MISO_OE), 32'd0);
        idle_cycles(HALF);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        @(negedge CLOCK);
        C_POL = cpol;
        C_PH  = cpha;
        SCK   = cpol;
        idle_cycles(HALF);
    endtask

    task automatic do_vector(input vec_t v);
        logic [7:0] got;
        set_mode(v.cpol, v.cpha);
        if (v.do_load) begin
            load_tx(v.tx);
            check("tx_ready_after_load", 32'(TX_READY), 32'd0);
        end
        push_rx(v.exp_rx);
        @(negedge CLOCK);
        SS = 1'b0;
        idle_cycles(HALF);
        check("busy_in_frame", 32'(BUSY), 32'd1);
        check("miso_oe_in_frame", 32'(MISO_OE), 32'd1);
        run_frame(v.cpol, v.cpha, v.mosi, 8, got);
        check("miso_frame", 32'(got), 32'(v.exp_miso));
        end_frame();
        check("tx_ready_after_frame", 32'(TX_READY), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_miso_oe", 32'(MISO_OE), 32'd0);
        check("rst_rx_data", 32'(RX_DATA), 32'd0);
        check("rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("rst_tx_ready", 32'(TX_READY), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation time limit, expected summary before it");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int         n;
        int         seen_before;

        RST = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        C_POL = 1'b0; C_PH = 1'b0; TX_LOAD = 1'b0; TX_DATA = '0;
        repeat (3) @(negedge CLOCK);
        check_reset_outputs();
        RST = 1'b1;
        idle_cycles(HALF);

        vecs[0] = '{cpol: 1'b0, cpha: 1'b0, do_load: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[1] = '{cpol: 1'b0, cpha: 1'b1, do_load: 1'b1, tx: 8'h7E, mosi: 8'h81, exp_rx: 8'h81, exp_miso: 8'h7E};
        vecs[2] = '{cpol: 1'b1, cpha: 1'b0, do_load: 1'b1, tx: 8'h7E, mosi: 8'h81, exp_rx: 8'h81, exp_miso: 8'h7E};
        vecs[3] = '{cpol: 1'b1, cpha: 1'b1, do_load: 1'b1, tx: 8'h7E, mosi: 8'h81, exp_rx: 8'h81, exp_miso: 8'h7E};
        vecs[4] = '{cpol: 1'b0, cpha: 1'b0, do_load: 1'b0, tx: 8'h00, mosi: 8'h5A, exp_rx: 8'h5A, exp_miso: 8'h00};
        vecs[5] = '{cpol: 1'b1, cpha: 1'b1, do_load: 1'b0, tx: 8'h00, mosi: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h00};
        for (int i = 0; i < 6; i++) do_vector(vecs[i]);

        // Back-to-back frames under one select, holding register refilled mid-frame.
        set_mode(1'b0, 1'b0);
        load_tx(8'hC3);
        push_rx(8'h11);
        push_rx(8'h22);
        @(negedge CLOCK);
        SS = 1'b0;
        idle_cycles(HALF);
        n = 0;
        while (TX_READY !== 1'b1 && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        check("b2b_tx_ready", 32'(TX_READY), 32'd1);
        load_tx(8'h96);
        run_frame(1'b0, 1'b0, 8'h11, 8, m1);
        run_frame(1'b0, 1'b0, 8'h22, 8, m2);
        end_frame();
        check("b2b_miso_1", 32'(m1), 32'hC3);
        check("b2b_miso_2", 32'(m2), 32'h96);

        // Abort after 5 bits, then a full frame.
        seen_before = rx_seen;
        @(negedge CLOCK);
        SS = 1'b0;
        idle_cycles(HALF);
        run_frame(1'b0, 1'b0, 8'hAA, 5, m1);
        end_frame();
        check("abort_no_rx_valid", 32'(rx_seen), 32'(seen_before));
        check("abort_rx_data_kept", 32'(RX_DATA), 32'h22);
        do_vector('{cpol: 1'b0, cpha: 1'b0, do_load: 1'b1, tx: 8'h5A, mosi: 8'hF0, exp_rx: 8'hF0, exp_miso: 8'h5A});

        // TX_LOAD in the same cycle as the frame-start reload: frame sends zeros, data stays held.
        push_rx(8'h69);
        @(negedge CLOCK);
        SS = 1'b0;
        repeat (SYNC + 1) @(negedge CLOCK);
        TX_DATA = 8'hE7;
        TX_LOAD = 1'b1;
        @(negedge CLOCK);
        TX_LOAD = 1'b0;
        idle_cycles(2);
        check("prio_still_held", 32'(TX_READY), 32'd0);
        run_frame(1'b0, 1'b0, 8'h69, 8, m1);
        end_frame();
        check("prio_miso_zero", 32'(m1), 32'h00);

        // Reset mid-frame with select still low, then a clean frame.
        load_tx(8'h55);
        @(negedge CLOCK);
        SS = 1'b0;
        idle_cycles(HALF);
        run_frame(1'b0, 1'b0, 8'h0F, 3, m1);
        @(negedge CLOCK);
        RST = 1'b0;
        @(negedge CLOCK);
        check_reset_outputs();
        RST = 1'b1;
        idle_cycles(12);
        check("rst_stays_idle", 32'(BUSY), 32'd0);
        @(negedge CLOCK);
        SS = 1'b1;
        idle_cycles(HALF);
        load_tx(8'h3C);
        load_tx(8'hFF);
        do_vector('{cpol: 1'b0, cpha: 1'b0, do_load: 1'b0, tx: 8'h00, mosi: 8'h96, exp_rx: 8'h96, exp_miso: 8'h3C});

        idle_cycles(HALF);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("rx_strobe_count", 32'(rx_seen), 32'(rx_pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
